// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory access controller:
// access sizes, controller states, strobe/lane/alignment functions.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } mem_state_e;

  function automatic logic [3:0] gen_strobe(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: gen_strobe = 4'b0001 << a;
      SZ_HALF: gen_strobe = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: gen_strobe = 4'b1111;
      default: gen_strobe = 4'b0000;
    endcase
  endfunction

  // Store data arrives right-aligned; copy it into every lane it could occupy.
  function automatic logic [31:0] replicate_lanes(input logic [1:0] size, input logic [31:0] w);
    case (size)
      SZ_BYTE: replicate_lanes = {4{w[7:0]}};
      SZ_HALF: replicate_lanes = {2{w[15:0]}};
      default: replicate_lanes = w;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    misaligned = (size == 2'd3) ||
                 ((size == SZ_HALF) && a[0]) ||
                 ((size == SZ_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-path alignment: move the addressed lane to bit 0,
// then sign- or zero-extend to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    result_o = shifted;
    case (size_i)
      SZ_BYTE: result_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_sram_ctrl.sv
// Memory-stage access controller: one outstanding request over an
// addr_ok/data_ok bus with sizing, alignment errors and a sticky timeout.
module data_sram_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              adel,
  output logic              ades,
  output logic              timeout_err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata,
  output mem_state_e        dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_TRIP = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);

  mem_state_e        state_q, state_d;
  logic              wr_q, wr_d, sgn_q, sgn_d, err_q, err_d, tout_q, tout_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d, load_res;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy, in_addr, in_resp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_ADDR) || (state_q == ST_DATA);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    tout_d  = tout_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          sgn_d   = req_signed;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = misaligned(req_size, req_addr[1:0]);
          state_d = err_d ? ST_RESP : ST_ADDR;
        end
      end
      ST_ADDR: if (mem_addr_ok) state_d = ST_DATA;
      // data_ok is only honoured here, so one coinciding with addr_ok is dropped.
      ST_DATA: if (mem_data_ok) begin
        rdata_d = mem_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // cnt_q holds the number of busy cycles already spent in this access.
    if ((state_q != ST_ADDR) && (state_d == ST_ADDR)) cnt_d = '0;
    else if (busy && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    if (busy && (cnt_q == CNT_TRIP)) tout_d = 1'b1;
  end

  load_align u_load_align (
    .rdata_i  (rdata_q),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .result_o (load_res)
  );

  assign in_addr     = (state_q == ST_ADDR);
  assign in_resp     = (state_q == ST_RESP);
  assign stall       = ((state_q == ST_IDLE) && req_valid) || busy;
  assign rsp_valid   = in_resp;
  assign rsp_rdata   = (in_resp && !wr_q && !err_q) ? load_res : 32'd0;
  assign adel        = in_resp && err_q && !wr_q;
  assign ades        = in_resp && err_q && wr_q;
  assign timeout_err = tout_q;
  assign mem_req     = in_addr;
  assign mem_wr      = in_addr && wr_q;
  assign mem_wstrb   = (in_addr && wr_q) ? gen_strobe(size_q, addr_q[1:0]) : 4'b0000;
  assign mem_addr    = in_addr ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata   = (in_addr && wr_q) ? replicate_lanes(size_q, wdata_q) : 32'd0;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: dut_a uses the default timeout, dut_b a
// timeout of 4 cycles; both see identical stimulus.
module tb_data_sram_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_wr, req_signed;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic a_stall, a_rsp_valid, a_adel, a_ades, a_timeout_err, a_mem_req, a_mem_wr;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0] a_mem_wstrb;
  mem_state_e a_state;
  logic b_stall, b_rsp_valid, b_adel, b_ades, b_timeout_err, b_mem_req, b_mem_wr;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0] b_mem_wstrb;
  mem_state_e b_state;

  int tests_run = 0;
  int tests_failed = 0;

  int obs_rsp_cyc;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0] obs_wstrb;
  logic obs_adel, obs_ades, obs_wr, obs_req_seen, obs_unstable, obs_stall_ok, obs_rsp_stall;

  always #5 clk = ~clk;

  data_sram_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(256)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(a_stall), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .adel(a_adel),
    .ades(a_ades), .timeout_err(a_timeout_err), .mem_req(a_mem_req), .mem_wr(a_mem_wr),
    .mem_wstrb(a_mem_wstrb), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .dbg_state(a_state)
  );

  data_sram_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(b_stall), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .adel(b_adel),
    .ades(b_ades), .timeout_err(b_timeout_err), .mem_req(b_mem_req), .mem_wr(b_mem_wr),
    .mem_wstrb(b_mem_wstrb), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .dbg_state(b_state)
  );

  // Driver: one request at cycle 0, bus answers addr_ok after addr_wait
  // mem_req cycles and data_ok after data_wait DATA cycles; records what dut_a did.
  task automatic run_access(input logic wr, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int addr_wait, input int data_wait);
    int cyc, aw, dw;
    bit addr_done;
    obs_rsp_cyc = -1; obs_rdata = '0; obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
    obs_adel = 0; obs_ades = 0; obs_wr = 0; obs_req_seen = 0; obs_unstable = 0;
    obs_stall_ok = 1; obs_rsp_stall = 1;
    cyc = 0; aw = 0; dw = 0; addr_done = 0;
    @(posedge clk); #1;
    req_valid = 1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; mem_addr_ok = 0; mem_data_ok = 0;
    @(negedge clk);
    if (!a_stall) obs_stall_ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      cyc++;
      mem_addr_ok = 0; mem_data_ok = 0;
      if (a_rsp_valid) begin
        obs_rsp_cyc = cyc; obs_rdata = a_rsp_rdata; obs_adel = a_adel; obs_ades = a_ades;
        obs_rsp_stall = a_stall; req_valid = 0;
        break;
      end
      if (a_mem_req) begin
        if (!obs_req_seen) begin
          obs_addr = a_mem_addr; obs_wdata = a_mem_wdata; obs_wstrb = a_mem_wstrb; obs_wr = a_mem_wr;
        end else if ({obs_addr, obs_wdata, obs_wstrb, obs_wr} !== {a_mem_addr, a_mem_wdata, a_mem_wstrb, a_mem_wr}) begin
          obs_unstable = 1;
        end
        obs_req_seen = 1;
        if (aw == addr_wait) begin mem_addr_ok = 1; addr_done = 1; end
        else aw++;
      end else if (addr_done) begin
        if (dw == data_wait) begin mem_data_ok = 1; mem_rdata = rdata; end
        else dw++;
      end
      @(negedge clk);
      if (!a_stall) obs_stall_ok = 0;
    end
    if (obs_rsp_cyc < 0) begin
      req_valid = 0;
      tests_run++; tests_failed++;
      $display("FAIL run_access_timeout: no rsp_valid within 64 cycles (addr %h)", addr);
    end
  endtask

  task automatic test_reset();
    rst = 0; req_valid = 0; req_wr = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (a_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", a_state, ST_IDLE); end
    tests_run++;
    if ({a_stall, a_rsp_valid, a_mem_req, a_mem_wr, a_adel, a_ades, a_timeout_err, b_timeout_err} !== 8'h00) begin
      tests_failed++; $display("FAIL reset_ctrl_outputs: got %b expected 00000000",
        {a_stall, a_rsp_valid, a_mem_req, a_mem_wr, a_adel, a_ades, a_timeout_err, b_timeout_err});
    end
    tests_run++;
    if ({a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_wstrb} !== 100'd0) begin
      tests_failed++; $display("FAIL reset_data_outputs: got %h %h %h %h expected all 0",
        a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_wstrb);
    end
    @(posedge clk); #1; rst = 1;
  endtask

  task automatic test_load_byte();
    run_access(1'b0, SZ_BYTE, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
    tests_run++;
    if (obs_addr !== 32'h0000_1000) begin tests_failed++; $display("FAIL lb_mem_addr: got %h expected 00001000", obs_addr); end
    tests_run++;
    if (obs_rsp_cyc !== 3) begin tests_failed++; $display("FAIL lb_latency: got %0d expected 3", obs_rsp_cyc); end
    tests_run++;
    if (obs_rdata !== 32'hFFFF_FF80) begin tests_failed++; $display("FAIL lb_rdata: got %h expected ffffff80", obs_rdata); end
    tests_run++;
    if ({obs_wr, obs_wstrb, obs_wdata} !== 37'd0) begin
      tests_failed++; $display("FAIL lb_read_bus: got wr=%b wstrb=%b wdata=%h expected all 0", obs_wr, obs_wstrb, obs_wdata);
    end
    tests_run++;
    if ({obs_stall_ok, obs_rsp_stall} !== 2'b10) begin
      tests_failed++; $display("FAIL lb_stall: got busy_ok=%b resp_stall=%b expected 1 0", obs_stall_ok, obs_rsp_stall);
    end
    @(posedge clk); #1;
    tests_run++;
    if (a_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL lb_rsp_one_cycle: got %b expected 0", a_rsp_valid); end
  endtask

  task automatic test_store();
    run_access(1'b1, SZ_HALF, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'hDEAD_DEAD, 0, 0);
    tests_run++;
    if ({obs_wr, obs_wstrb, obs_wdata, obs_addr} !== {1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000}) begin
      tests_failed++; $display("FAIL sh_bus: got wr=%b wstrb=%b wdata=%h addr=%h expected 1 1100 beefbeef 00002000",
        obs_wr, obs_wstrb, obs_wdata, obs_addr);
    end
    tests_run++;
    if ({obs_rdata, obs_ades} !== 33'd0) begin tests_failed++; $display("FAIL sh_rsp: got rdata=%h ades=%b expected 0 0", obs_rdata, obs_ades); end
    run_access(1'b1, SZ_BYTE, 1'b0, 32'h0000_3001, 32'h0000_00A5, 32'h0, 0, 0);
    tests_run++;
    if ({obs_wstrb, obs_wdata, obs_rsp_cyc} !== {4'b0010, 32'hA5A5_A5A5, 32'd3}) begin
      tests_failed++; $display("FAIL sb_bus: got wstrb=%b wdata=%h cyc=%0d expected 0010 a5a5a5a5 3", obs_wstrb, obs_wdata, obs_rsp_cyc);
    end
  endtask

  task automatic test_addr_errors();
    run_access(1'b0, SZ_WORD, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0, 0);
    tests_run++;
    if ({obs_rsp_cyc, obs_adel, obs_ades, obs_req_seen} !== {32'd1, 3'b100}) begin
      tests_failed++; $display("FAIL lw_misaligned: got cyc=%0d adel=%b ades=%b req_seen=%b expected 1 1 0 0",
        obs_rsp_cyc, obs_adel, obs_ades, obs_req_seen);
    end
    run_access(1'b1, SZ_HALF, 1'b0, 32'h0000_0001, 32'h1234, 32'h0, 0, 0);
    tests_run++;
    if ({obs_rsp_cyc, obs_adel, obs_ades, obs_req_seen} !== {32'd1, 3'b010}) begin
      tests_failed++; $display("FAIL sh_misaligned: got cyc=%0d adel=%b ades=%b req_seen=%b expected 1 0 1 0",
        obs_rsp_cyc, obs_adel, obs_ades, obs_req_seen);
    end
    run_access(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, 0);
    tests_run++;
    if ({obs_rsp_cyc, obs_adel, obs_req_seen, obs_rdata} !== {32'd1, 2'b10, 32'd0}) begin
      tests_failed++; $display("FAIL size3_illegal: got cyc=%0d adel=%b req_seen=%b rdata=%h expected 1 1 0 0",
        obs_rsp_cyc, obs_adel, obs_req_seen, obs_rdata);
    end
  endtask

  task automatic test_load_extend();
    run_access(1'b0, SZ_HALF, 1'b0, 32'h0000_0002, 32'h0, 32'h80FF_1234, 0, 0);
    tests_run++;
    if (obs_rdata !== 32'h0000_80FF) begin tests_failed++; $display("FAIL lhu_rdata: got %h expected 000080ff", obs_rdata); end
    run_access(1'b0, SZ_HALF, 1'b1, 32'h0000_0002, 32'h0, 32'h80FF_1234, 0, 0);
    tests_run++;
    if (obs_rdata !== 32'hFFFF_80FF) begin tests_failed++; $display("FAIL lh_rdata: got %h expected ffff80ff", obs_rdata); end
    run_access(1'b0, SZ_BYTE, 1'b0, 32'h0000_0001, 32'h0, 32'h80FF_1234, 0, 0);
    tests_run++;
    if (obs_rdata !== 32'h0000_0012) begin tests_failed++; $display("FAIL lbu_rdata: got %h expected 00000012", obs_rdata); end
    run_access(1'b0, SZ_WORD, 1'b1, 32'h0000_0004, 32'h0, 32'h80FF_1234, 0, 0);
    tests_run++;
    if ({obs_rdata, obs_addr} !== {32'h80FF_1234, 32'h0000_0004}) begin
      tests_failed++; $display("FAIL lw_rdata: got %h addr %h expected 80ff1234 00000004", obs_rdata, obs_addr);
    end
    run_access(1'b0, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0, 32'h0BAD_F00D, 1, 0);
    tests_run++;
    if ({b_timeout_err, obs_rsp_cyc} !== {1'b0, 32'd4}) begin
      tests_failed++; $display("FAIL three_busy_no_timeout: got tout=%b cyc=%0d expected 0 4", b_timeout_err, obs_rsp_cyc);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, 32'h5555_AAAA, 0, 10);
    tests_run++;
    if ({b_timeout_err, a_timeout_err} !== 2'b10) begin
      tests_failed++; $display("FAIL timeout_set: got b=%b a=%b expected 1 0", b_timeout_err, a_timeout_err);
    end
    tests_run++;
    if ({obs_rsp_cyc, obs_rdata} !== {32'd13, 32'h5555_AAAA}) begin
      tests_failed++; $display("FAIL timeout_completes: got cyc=%0d rdata=%h expected 13 5555aaaa", obs_rsp_cyc, obs_rdata);
    end
    run_access(1'b0, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h0, 32'h7700_0000, 0, 0);
    tests_run++;
    if ({b_timeout_err, obs_rdata} !== {1'b1, 32'h0000_0077}) begin
      tests_failed++; $display("FAIL timeout_sticky: got tout=%b rdata=%h expected 1 00000077", b_timeout_err, obs_rdata);
    end
  endtask

  task automatic test_wait_states();
    run_access(1'b1, SZ_WORD, 1'b0, 32'h0000_0040, 32'h1122_3344, 32'h0, 3, 1);
    tests_run++;
    if (obs_rsp_cyc !== 7) begin tests_failed++; $display("FAIL wait_latency: got %0d expected 7", obs_rsp_cyc); end
    tests_run++;
    if ({obs_unstable, obs_stall_ok, obs_rsp_stall} !== 3'b010) begin
      tests_failed++; $display("FAIL wait_stable_stall: got unstable=%b stall_ok=%b resp_stall=%b expected 0 1 0",
        obs_unstable, obs_stall_ok, obs_rsp_stall);
    end
    tests_run++;
    if ({obs_wstrb, obs_wdata, obs_addr} !== {4'b1111, 32'h1122_3344, 32'h0000_0040}) begin
      tests_failed++; $display("FAIL wait_bus: got wstrb=%b wdata=%h addr=%h expected 1111 11223344 00000040",
        obs_wstrb, obs_wdata, obs_addr);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req_valid = 1; req_wr = 0; req_size = SZ_WORD; req_signed = 0; req_addr = 32'h0000_0020;
    @(posedge clk); #1;
    mem_addr_ok = 1;
    @(posedge clk); #1;
    mem_addr_ok = 0;
    tests_run++;
    if (a_state !== ST_DATA) begin tests_failed++; $display("FAIL mid_reach_data: got %0d expected %0d", a_state, ST_DATA); end
    rst = 0;
    @(posedge clk); #1;
    rst = 1; req_valid = 0; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    tests_run++;
    if ({a_stall, a_rsp_valid, a_mem_req, a_adel, a_timeout_err, b_timeout_err, a_rsp_rdata, a_mem_addr} !== 70'd0) begin
      tests_failed++; $display("FAIL mid_reset_outputs: got stall=%b rsp=%b req=%b tout=%b/%b rdata=%h addr=%h expected all 0",
        a_stall, a_rsp_valid, a_mem_req, a_timeout_err, b_timeout_err, a_rsp_rdata, a_mem_addr);
    end
    @(posedge clk); #1;
    mem_data_ok = 0;
    tests_run++;
    if ({a_rsp_valid, a_state} !== {1'b0, ST_IDLE}) begin
      tests_failed++; $display("FAIL mid_stray_data_ok: got rsp=%b state=%0d expected 0 0", a_rsp_valid, a_state);
    end
    run_access(1'b0, SZ_WORD, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 0, 0);
    tests_run++;
    if ({obs_rsp_cyc, obs_rdata, obs_addr} !== {32'd3, 32'hCAFE_F00D, 32'h0000_0020}) begin
      tests_failed++; $display("FAIL mid_next_access: got cyc=%0d rdata=%h addr=%h expected 3 cafef00d 00000020",
        obs_rsp_cyc, obs_rdata, obs_addr);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store();
    test_addr_errors();
    test_load_extend();
    test_timeout();
    test_wait_states();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_sram_ctrl.md
# data_sram_ctrl

Parametrised data-memory access controller between the CPU datapath's memory stage and an SRAM-like bus with variable latency. It replaces the fixed single-cycle SRAM port (memwrite/wea/aluout/writedata/readdata), which has no wait states. It adds:
- byte/half/word sizing with lane steering and load sign/zero extension;
- an address/data handshake with pipeline stall;
- address-error detection and a timeout monitor.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYC, 256, cycles in ADDR or DATA before timeout_err sets; must be ≥2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  memory-stage request present; held by the pipeline while stall=1.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  freeze pipeline.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  aligned, extended load data; 0 for stores.
- adel  out  1  load address error, with rsp_valid.
- ades  out  1  store address error, with rsp_valid.
- timeout_err  out  1  sticky timeout flag.
- mem_req  out  1  bus request.
- mem_wr  out  1  bus write.
- mem_wstrb  out  4  byte strobes; 0 on reads.
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_addr_ok  in  1  address accepted.
- mem_data_ok  in  1  read data valid / write done.
- mem_rdata  in  32  read data.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On req_valid, register the request.
  - Illegal request → RESP with the error flag set and no bus access. Illegal means size=3, half with addr[0]=1, or word with addr[1:0]≠0.
  - Legal request → ADDR.
  - mem_data_ok and mem_addr_ok are ignored in IDLE.
- ADDR: mem_req=1 and all mem_* outputs stable until mem_addr_ok=1, then → DATA.
- DATA: mem_req=0. On mem_data_ok, capture mem_rdata and → RESP. A mem_data_ok in the same cycle as mem_addr_ok in ADDR is not accepted.
- RESP: rsp_valid=1 for exactly one cycle, then → IDLE.
- stall = (IDLE & req_valid) | ADDR | DATA. stall is 0 in RESP.
- Byte strobes (a = addr[1:0]):
  - byte: 4'b0001<<a.
  - half: 4'b0011<<{a[1],0}.
  - word: 4'b1111.
- Store data: byte replicated ×4, half replicated ×2.
- Load data: shift mem_rdata right by 8·a, take the low 8/16/32 bits, then sign- or zero-extend per req_signed.
- Timeout counter:
  - Counts cycles in ADDR ∪ DATA and clears on entering ADDR.
  - Reaching TIMEOUT_CYC sets timeout_err. The transaction is not aborted.
  - timeout_err clears only on reset.

## Timing
- Reset (rst=0 at a clock edge):
  - state=IDLE; counter=0.
  - All outputs 0: stall, rsp_valid, rsp_rdata, adel, ades, timeout_err, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata.
- Reset mid-transaction abandons the transaction. A later mem_data_ok is ignored.
- Minimum legal-access latency, with the request at cycle 0:
  - cycle 1: mem_req, with mem_addr_ok=1.
  - cycle 2: mem_data_ok.
  - cycle 3: rsp_valid.
- Each wait cycle of addr_ok or data_ok adds one cycle.
- Error path: request at cycle 0 → rsp_valid plus adel/ades at cycle 1. mem_req stays 0.
- The next request is accepted no earlier than the cycle after RESP.
- At most one outstanding transaction.

## Structure
- Package mem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum;
  - functions: strobe generation, store lane replication, misalignment check.
- Sub-module load_align is combinational: rdata, offset, size, signed → 32-bit result.

## Test plan
- Load byte signed at addr 0x1003, mem_rdata=0x80FF_1234, zero-wait bus → mem_addr=0x1000 at cycle 1, rsp_rdata=0xFFFF_FF80 with rsp_valid at cycle 3.
- Store half 0xBEEF at 0x2002 → mem_wstrb=4'b1100, mem_wdata=0xBEEF_BEEF, mem_wr=1; rsp_rdata=0.
- Load word at 0x0006 → adel=1 and rsp_valid=1 at cycle 1, mem_req never asserted.
- Bus holds addr_ok low 3 cycles, then data_ok 2 cycles later:
  - mem_* outputs stay stable while waiting;
  - stall stays high throughout;
  - rsp_valid at cycle 7.
- TIMEOUT_CYC=4 with mem_data_ok withheld 10 cycles → timeout_err set; the transaction then completes normally and timeout_err stays set.
- rst=0 during DATA, then a stray mem_data_ok → outputs 0, no rsp_valid, and the next request behaves as from reset.
